// File: rtl/pipe_pkg.sv
// Shared widths, forward-select encodings and stage payloads for the E/M/W
// pipeline-register tracker.
package pipe_pkg;

    localparam int unsigned DW = 32;
    localparam int unsigned RA = 5;

    localparam logic [RA-1:0] JAL_REG = 5'd31;

    localparam logic [1:0] FWD_QA   = 2'b00;
    localparam logic [1:0] FWD_EALU = 2'b01;
    localparam logic [1:0] FWD_MALU = 2'b10;
    localparam logic [1:0] FWD_MMO  = 2'b11;

    typedef struct packed {
        logic          wreg;
        logic          m2reg;
        logic          wmem;
        logic          jal;
        logic [RA-1:0] rn;
        logic [DW-1:0] pc4;
    } e_stage_t;

    typedef struct packed {
        logic          wreg;
        logic          m2reg;
        logic          wmem;
        logic [RA-1:0] rn;
        logic [DW-1:0] alu;
    } m_stage_t;

    typedef struct packed {
        logic          wreg;
        logic          m2reg;
        logic [RA-1:0] rn;
        logic [DW-1:0] mo;
        logic [DW-1:0] alu;
    } w_stage_t;

    // Four-way operand forward mux shared by both ID-stage operands.
    function automatic logic [DW-1:0] fwd_mux(
        input logic [1:0]    sel,
        input logic [DW-1:0] rf,
        input logic [DW-1:0] ealu,
        input logic [DW-1:0] malu,
        input logic [DW-1:0] mmo
    );
        logic [DW-1:0] r;
        r = rf;
        case (sel)
            FWD_EALU: r = ealu;
            FWD_MALU: r = malu;
            FWD_MMO:  r = mmo;
            default:  r = rf;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline boundary register: async active-low clear, synchronous enable.
module pipe_stage_reg #(
    parameter int unsigned W = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/pipe_emw_track.sv
// D->E, E->M, M->W destination/write-control pipeline registers, hazard status
// for the control unit, and the forwarded ID-stage operands.
module pipe_emw_track
    import pipe_pkg::*;
(
    input  logic          clock,
    input  logic          resetn,
    input  logic          wpcir,
    input  logic          dwreg,
    input  logic          dm2reg,
    input  logic          dwmem,
    input  logic          djal,
    input  logic          dregrt,
    input  logic [RA-1:0] drs,
    input  logic [RA-1:0] drt,
    input  logic [RA-1:0] drd,
    input  logic [DW-1:0] dpc4,
    input  logic [DW-1:0] qa,
    input  logic [DW-1:0] qb,
    input  logic [1:0]    fwda,
    input  logic [1:0]    fwdb,
    input  logic [DW-1:0] ealu,
    input  logic [DW-1:0] mmo,
    output logic [DW-1:0] da,
    output logic [DW-1:0] db,
    output logic          ewreg,
    output logic          em2reg,
    output logic          ewmem,
    output logic [RA-1:0] ern,
    output logic [DW-1:0] eres,
    output logic          mwreg,
    output logic          mm2reg,
    output logic          mwmem,
    output logic [RA-1:0] mrn,
    output logic [DW-1:0] malu,
    output logic          wwreg,
    output logic [RA-1:0] wrn,
    output logic [DW-1:0] wdi
);

    e_stage_t e_d, e_q;
    m_stage_t m_d, m_q;
    w_stage_t w_d, w_q;

    // rs is carried only for trace; keep it visibly consumed.
    logic unused_drs;
    assign unused_drs = ^drs;

    // D-stage capture; a load-use stall injects a bubble into E.
    always_comb begin
        e_d = '0;
        if (wpcir) begin
            e_d.wreg  = dwreg;
            e_d.m2reg = dm2reg;
            e_d.wmem  = dwmem;
            e_d.jal   = djal;
            e_d.rn    = djal ? JAL_REG : (dregrt ? drt : drd);
            e_d.pc4   = dpc4;
        end
    end

    assign eres = e_q.jal ? (e_q.pc4 + DW'(4)) : ealu;

    always_comb begin
        m_d       = '0;
        m_d.wreg  = e_q.wreg;
        m_d.m2reg = e_q.m2reg;
        m_d.wmem  = e_q.wmem;
        m_d.rn    = e_q.rn;
        m_d.alu   = eres;
    end

    always_comb begin
        w_d       = '0;
        w_d.wreg  = m_q.wreg;
        w_d.m2reg = m_q.m2reg;
        w_d.rn    = m_q.rn;
        w_d.mo    = mmo;
        w_d.alu   = m_q.alu;
    end

    pipe_stage_reg #(.W($bits(e_stage_t))) u_e_reg (
        .clk_i (clock),
        .rst_ni(resetn),
        .en_i  (1'b1),
        .d_i   (e_d),
        .q_o   (e_q)
    );

    pipe_stage_reg #(.W($bits(m_stage_t))) u_m_reg (
        .clk_i (clock),
        .rst_ni(resetn),
        .en_i  (1'b1),
        .d_i   (m_d),
        .q_o   (m_q)
    );

    pipe_stage_reg #(.W($bits(w_stage_t))) u_w_reg (
        .clk_i (clock),
        .rst_ni(resetn),
        .en_i  (1'b1),
        .d_i   (w_d),
        .q_o   (w_q)
    );

    assign ewreg  = e_q.wreg;
    assign em2reg = e_q.m2reg;
    assign ewmem  = e_q.wmem;
    assign ern    = e_q.rn;

    assign mwreg  = m_q.wreg;
    assign mm2reg = m_q.m2reg;
    assign mwmem  = m_q.wmem;
    assign mrn    = m_q.rn;
    assign malu   = m_q.alu;

    // r0 is hardwired zero, so a write to it never reaches the register file.
    assign wwreg  = w_q.wreg & (w_q.rn != '0);
    assign wrn    = w_q.rn;
    assign wdi    = w_q.m2reg ? w_q.mo : w_q.alu;

    assign da = fwd_mux(fwda, qa, ealu, malu, mmo);
    assign db = fwd_mux(fwdb, qb, ealu, malu, mmo);

endmodule

// File: tb/tb_pipe_emw_track.sv
// Scoreboard bench for pipe_emw_track: each issued D-stage instruction queues
// its expected E, then M, then W contents, which are popped as it advances.
module tb_pipe_emw_track;

    logic        clock = 1'b0;
    logic        resetn;
    logic        wpcir, dwreg, dm2reg, dwmem, djal, dregrt;
    logic [4:0]  drs, drt, drd;
    logic [31:0] dpc4, qa, qb, ealu, mmo;
    logic [1:0]  fwda, fwdb;
    logic [31:0] da, db, eres, malu, wdi;
    logic        ewreg, em2reg, ewmem, mwreg, mm2reg, mwmem, wwreg;
    logic [4:0]  ern, mrn, wrn;

    int n_chk = 0;
    int n_err = 0;

    typedef struct packed {
        logic        wpcir;
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic        jal;
        logic        regrt;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] pc4;
    } stim_t;

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic        jal;
        logic [4:0]  rn;
        logic [31:0] pc4;
        logic [31:0] res;
    } exp_t;

    exp_t qe[$];
    exp_t qm[$];
    exp_t qw[$];

    always #5 clock = ~clock;

    pipe_emw_track dut (
        .clock (clock),  .resetn(resetn), .wpcir(wpcir),
        .dwreg (dwreg),  .dm2reg(dm2reg), .dwmem(dwmem),
        .djal  (djal),   .dregrt(dregrt), .drs  (drs),
        .drt   (drt),    .drd   (drd),    .dpc4 (dpc4),
        .qa    (qa),     .qb    (qb),     .fwda (fwda),
        .fwdb  (fwdb),   .ealu  (ealu),   .mmo  (mmo),
        .da    (da),     .db    (db),     .ewreg(ewreg),
        .em2reg(em2reg), .ewmem (ewmem),  .ern  (ern),
        .eres  (eres),   .mwreg (mwreg),  .mm2reg(mm2reg),
        .mwmem (mwmem),  .mrn   (mrn),    .malu (malu),
        .wwreg (wwreg),  .wrn   (wrn),    .wdi  (wdi)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf,
                                         input logic [31:0] alu_e, input logic [31:0] alu_m,
                                         input logic [31:0] mo);
        case (sel)
            2'b00:   return rf;
            2'b01:   return alu_e;
            2'b10:   return alu_m;
            default: return mo;
        endcase
    endfunction

    function automatic stim_t mk(input logic w, input logic wr, input logic m2, input logic wm,
                                 input logic j, input logic rgt, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [31:0] pc);
        stim_t s;
        s.wpcir = w;  s.wreg = wr;   s.m2reg = m2; s.wmem = wm; s.jal = j;
        s.regrt = rgt; s.rt = rt;    s.rd = rd;    s.pc4 = pc;
        return s;
    endfunction

    task automatic prime();
        qe.delete(); qm.delete(); qw.delete();
        qe.push_back('0); qm.push_back('0); qw.push_back('0);
    endtask

    // One clock of pipeline: check E/M/W against queue heads, issue s, advance.
    task automatic run(input stim_t s);
        exp_t e, m, w, nm, nw, ne;
        logic [31:0] eres_x;
        e = qe.pop_front();
        m = qm.pop_front();
        w = qw.pop_front();
        check("ewreg",  32'(ewreg),  32'(e.wreg));
        check("em2reg", 32'(em2reg), 32'(e.m2reg));
        check("ewmem",  32'(ewmem),  32'(e.wmem));
        check("ern",    32'(ern),    32'(e.rn));
        check("mwreg",  32'(mwreg),  32'(m.wreg));
        check("mm2reg", 32'(mm2reg), 32'(m.m2reg));
        check("mwmem",  32'(mwmem),  32'(m.wmem));
        check("mrn",    32'(mrn),    32'(m.rn));
        check("malu",   malu,        m.res);
        check("wwreg",  32'(wwreg),  32'(w.wreg));
        check("wrn",    32'(wrn),    32'(w.rn));
        check("wdi",    wdi,         w.res);

        ealu = $urandom; mmo = $urandom; qa = $urandom; qb = $urandom;
        fwda = 2'($urandom_range(0, 3));
        fwdb = 2'($urandom_range(0, 3));
        wpcir = s.wpcir; dwreg = s.wreg; dm2reg = s.m2reg; dwmem = s.wmem;
        djal = s.jal; dregrt = s.regrt; drt = s.rt; drd = s.rd; dpc4 = s.pc4;
        drs = 5'($urandom);
        #1;
        eres_x = e.jal ? (e.pc4 + 32'd4) : ealu;
        check("eres", eres, eres_x);
        check("da", da, pick(fwda, qa, ealu, m.res, mmo));
        check("db", db, pick(fwdb, qb, ealu, m.res, mmo));

        nm = e;
        nm.res = eres_x;
        qm.push_back(nm);
        nw = m;
        nw.wreg = m.wreg && (m.rn != 5'd0);
        nw.res  = m.m2reg ? mmo : m.res;
        qw.push_back(nw);
        ne = '0;
        if (s.wpcir) begin
            ne.wreg = s.wreg; ne.m2reg = s.m2reg; ne.wmem = s.wmem; ne.jal = s.jal;
            ne.rn   = s.jal ? 5'd31 : (s.regrt ? s.rt : s.rd);
            ne.pc4  = s.pc4;
        end
        qe.push_back(ne);
        @(posedge clock);
        #1;
    endtask

    task automatic reset_mid();
        check("pre_rst_ewreg", 32'(ewreg), 32'(qe[0].wreg));
        check("pre_rst_mwreg", 32'(mwreg), 32'(qm[0].wreg));
        resetn = 1'b0;
        #1;
        check("rst_ewreg", 32'(ewreg), 32'd0);
        check("rst_mwreg", 32'(mwreg), 32'd0);
        check("rst_wwreg", 32'(wwreg), 32'd0);
        check("rst_ern",   32'(ern),   32'd0);
        check("rst_mrn",   32'(mrn),   32'd0);
        check("rst_em2reg", 32'(em2reg), 32'd0);
        prime();
        @(posedge clock);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0;
        wpcir = 1'b1; dwreg = 1'b0; dm2reg = 1'b0; dwmem = 1'b0; djal = 1'b0; dregrt = 1'b0;
        drs = '0; drt = '0; drd = '0; dpc4 = '0; qa = '0; qb = '0; ealu = '0; mmo = '0;
        fwda = 2'b00; fwdb = 2'b00;
        prime();
        #2;
        check("init_ewreg", 32'(ewreg), 32'd0);
        check("init_mwmem", 32'(mwmem), 32'd0);
        check("init_wwreg", 32'(wwreg), 32'd0);
        check("init_wrn",   32'(wrn),   32'd0);
        check("init_eres",  eres,       32'd0);
        check("init_malu",  malu,       32'd0);
        check("init_wdi",   wdi,        32'd0);

        fwda = 2'b01; ealu = 32'h0000_1234;
        fwdb = 2'b11; mmo  = 32'hDEAD_BEEF;
        #1;
        check("fwd_a_ealu", da, 32'h0000_1234);
        check("fwd_b_mmo",  db, 32'hDEAD_BEEF);
        fwda = 2'b00; qa = 32'd5;
        #1;
        check("fwd_a_qa", da, 32'd5);
        ealu = '0; mmo = '0;

        @(posedge clock);
        #1;
        resetn = 1'b1;

        run(mk(1, 1, 1, 0, 0, 1, 5'd7, 5'd0, 32'h200));   // lw r7
        run(mk(1, 1, 0, 0, 0, 0, 5'd0, 5'd3, 32'h204));   // add r3
        reset_mid();

        run(mk(1, 1, 0, 0, 1, 0, 5'd2, 5'd9, 32'h100));   // jal
        run(mk(1, 1, 1, 0, 0, 1, 5'd7, 5'd0, 32'h104));   // lw r7
        run(mk(0, 1, 0, 0, 0, 0, 5'd0, 5'd5, 32'h108));   // stalled add r5
        run(mk(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 32'h10C));   // write to r0
        run(mk(1, 1, 0, 0, 1, 0, 5'd0, 5'd0, 32'hFFFF_FFFC)); // jal, pc wraps
        run(mk(1, 0, 0, 1, 0, 1, 5'd4, 5'd0, 32'h110));   // sw
        run(mk(0, 1, 1, 1, 1, 1, 5'd8, 5'd8, 32'h114));   // stall hides everything
        for (int i = 0; i < 16; i++) begin
            run(mk(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom_range(0, 3) == 0), 1'($urandom), 5'($urandom), 5'($urandom),
                   $urandom));
        end
        for (int i = 0; i < 4; i++) begin
            run(mk(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 32'h0));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
